monitor_overlay: RTL and testbench
==================================

Name: monitor_overlay

Overview:
- Bus-routing stage directly upstream of the CPU control/monitor block.
- Watches the 6502 address bus and, after that block pulls NMI low, overlays the top page (default $FF00-$FFFF) onto the control block so the NMI vector and monitor code come from control ROM/registers.
- Drives the control block's 8-bit address, chip select and write strobe, plus the main-RAM select.
- Returns to normal mapping on a software exit write or on an arming timeout.

Parameters:
- OVERLAY_PAGE, 8'hFF: cpu_addr[15:8] value that is overlaid.
- VECTOR_LO, 8'hFA: low byte of the NMI vector address that triggers the overlay.
- EXIT_OFFSET, 8'hF8: low byte, within OVERLAY_PAGE, whose write ends the overlay.
- ARM_TIMEOUT, 64: cpu_valid strobes allowed in ARMED before abandoning.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cpu_addr  in  16  CPU address bus
- cpu_rw  in  1  1 = read, 0 = write (6502 convention)
- cpu_valid  in  1  one-cycle strobe marking a qualified bus cycle
- nmi_n  in  1  NMI line from the control block, active low
- ctl_addr  out  8  address to the control block, = cpu_addr[7:0]
- csP  out  1  control-block select
- write  out  1  control-block write strobe
- ram_cs  out  1  main-memory select
- overlay_active  out  1  registered, 1 while in OVERLAY
- arm_timeout  out  1  sticky flag: last arming expired without a vector fetch
- state  out  2  current state (debug)

Behaviour:
- Reset: synchronous, active-low, sampled on the clk rising edge. State -> NORMAL; nmi_n history reg -> 1; counter -> 0; overlay_active = 0; arm_timeout = 0. A reset asserted mid-overlay aborts it immediately.
- States:
  - NORMAL = 2'h0: all accesses go to RAM.
  - ARMED = 2'h1: all accesses go to RAM, except the vector hit.
  - OVERLAY = 2'h2: page accesses go to the control block.
  - 2'h3 is unreachable; if entered, treat as NORMAL next cycle.
- Falling-edge detect: nmi_fall = nmi_prev & ~nmi_n, with nmi_prev registered every cycle.
- NORMAL -> ARMED on nmi_fall. Counter cleared; arm_timeout cleared.
- ARMED:
  - Each cpu_valid increments the counter.
  - vector_hit = cpu_valid & cpu_rw & cpu_addr == {OVERLAY_PAGE, VECTOR_LO}. On vector_hit, go to OVERLAY next cycle. The hit access itself is routed to the control block in the same cycle (csP = 1, ram_cs = 0).
  - If the counter reaches ARM_TIMEOUT-1 on a cpu_valid without a hit, go to NORMAL and set arm_timeout.
  - If hit and timeout coincide, the hit wins.
- OVERLAY:
  - page_hit = cpu_addr[15:8] == OVERLAY_PAGE. A page_hit access goes to the control block; every other access goes to RAM.
  - exit_hit = cpu_valid & ~cpu_rw & cpu_addr == {OVERLAY_PAGE, EXIT_OFFSET}. The exit write is itself delivered to the control block (write = 1), then the state is NORMAL next cycle.
  - nmi_fall while in OVERLAY is ignored; there is no re-arm until back in NORMAL.
- Routing, combinational from state and bus, active only when cpu_valid:
  - csP = cpu_valid & (OVERLAY & page_hit | ARMED & vector_hit).
  - write = csP & ~cpu_rw.
  - ram_cs = cpu_valid & ~csP.
  - ctl_addr = cpu_addr[7:0] always.
- Latency:
  - Routing has zero added latency. The control block's own ROM read data arrives one clk later, and the CPU bus timing must allow this.
  - State changes take effect on the cycle after the triggering strobe.
- The counter is 8 bits wide; ARM_TIMEOUT must be ≤ 256.
- overlay_active is registered; it rises one cycle after vector_hit and falls one cycle after exit_hit.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with cpu_valid toggling -> state = 0, csP = 0, ram_cs follows cpu_valid, arm_timeout = 0.
- Normal run: reads at $FFFA with nmi_n = 1 -> ram_cs = 1, csP = 0, state stays 0.
- Full NMI entry:
  - nmi_n 1->0 -> state = 1 next cycle.
  - Read $FFFA -> csP = 1, ctl_addr = 8'hFA, ram_cs = 0 that cycle; state = 2 and overlay_active = 1 next cycle.
  - Read $FF10 -> csP = 1.
  - Read $1234 -> ram_cs = 1, csP = 0.
- Exit: in OVERLAY, write $FFF8 -> csP = 1, write = 1 that cycle, state = 0 next cycle. A following read of $FF10 -> ram_cs = 1.
- Timeout: arm, then 64 cpu_valid strobes to $0200 -> state = 0 after the 64th, arm_timeout = 1. Re-arm -> arm_timeout clears.
- Edge cases:
  - nmi_n pulses during OVERLAY -> state stays 2.
  - rst_n = 0 mid-OVERLAY -> state = 0 and overlay_active = 0 next edge.
  - Hit on the 64th strobe -> state = 2, arm_timeout = 0.

Source files
------------

// File: rtl/monitor_overlay.sv
// Bus-routing stage in front of the CPU control/monitor block. After the control block
// pulls NMI low, the top page is mapped onto control ROM/registers until the monitor exits.
module monitor_overlay #(
    parameter logic [7:0] OVERLAY_PAGE = 8'hFF,
    parameter logic [7:0] VECTOR_LO    = 8'hFA,
    parameter logic [7:0] EXIT_OFFSET  = 8'hF8,
    parameter int         ARM_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic        cpu_valid,
    input  logic        nmi_n,
    output logic [7:0]  ctl_addr,
    output logic        csP,
    output logic        write,
    output logic        ram_cs,
    output logic        overlay_active,
    output logic        arm_timeout,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'h0,
        ST_ARMED   = 2'h1,
        ST_OVERLAY = 2'h2
    } state_t;

    // The arm counter is 8 bits wide, so ARM_TIMEOUT must not exceed 256.
    localparam logic [7:0] ARM_LAST = 8'(ARM_TIMEOUT - 1);

    state_t     state_q;
    logic       nmi_prev;
    logic [7:0] arm_count;

    logic nmi_fall;
    logic page_hit;
    logic vector_hit;
    logic exit_hit;
    logic ctl_sel;

    assign nmi_fall   = nmi_prev & ~nmi_n;
    assign page_hit   = (cpu_addr[15:8] == OVERLAY_PAGE);
    assign vector_hit = cpu_valid & cpu_rw  & (cpu_addr == {OVERLAY_PAGE, VECTOR_LO});
    assign exit_hit   = cpu_valid & ~cpu_rw & (cpu_addr == {OVERLAY_PAGE, EXIT_OFFSET});

    // Routing is purely combinational so the selected device sees the access with no added latency.
    assign ctl_sel  = cpu_valid & (((state_q == ST_OVERLAY) & page_hit) |
                                   ((state_q == ST_ARMED) & vector_hit));
    assign csP      = ctl_sel;
    assign write    = ctl_sel & ~cpu_rw;
    assign ram_cs   = cpu_valid & ~ctl_sel;
    assign ctl_addr = cpu_addr[7:0];
    assign state    = state_q;

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch, not the sensitivity list.
        if (!rst_n) begin
            state_q        <= ST_NORMAL;
            nmi_prev       <= 1'b1;
            arm_count      <= 8'd0;
            overlay_active <= 1'b0;
            arm_timeout    <= 1'b0;
        end else begin
            nmi_prev <= nmi_n;
            case (state_q)
                ST_NORMAL: begin
                    if (nmi_fall) begin
                        state_q     <= ST_ARMED;
                        arm_count   <= 8'd0;
                        arm_timeout <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (cpu_valid) begin
                        arm_count <= arm_count + 8'd1;
                    end
                    // A vector fetch on the final allowed strobe still enters the overlay.
                    if (vector_hit) begin
                        state_q        <= ST_OVERLAY;
                        overlay_active <= 1'b1;
                    end else if (cpu_valid && arm_count == ARM_LAST) begin
                        state_q     <= ST_NORMAL;
                        arm_timeout <= 1'b1;
                    end
                end
                ST_OVERLAY: begin
                    if (exit_hit) begin
                        state_q        <= ST_NORMAL;
                        overlay_active <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= ST_NORMAL;
                    overlay_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_monitor_overlay.sv
// Directed bench for monitor_overlay: stimulus pushes hand-computed expectations into a
// queue, and a negedge monitor pops and compares them against the DUT outputs.
module tb_monitor_overlay;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic        cpu_valid;
    logic        nmi_n;
    logic [7:0]  ctl_addr;
    logic        csP;
    logic        write;
    logic        ram_cs;
    logic        overlay_active;
    logic        arm_timeout;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [7:0] addr;
        logic       cs;
        logic       ram;
        logic       wr;
        logic [1:0] st;
        logic       ov;
        logic       to;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    monitor_overlay dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_addr       (cpu_addr),
        .cpu_rw         (cpu_rw),
        .cpu_valid      (cpu_valid),
        .nmi_n          (nmi_n),
        .ctl_addr       (ctl_addr),
        .csP            (csP),
        .write          (write),
        .ram_cs         (ram_cs),
        .overlay_active (overlay_active),
        .arm_timeout    (arm_timeout),
        .state          (state)
    );

    task automatic check(input string name, input string field,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h at %0t", name, field, act, exp, $time);
        end
    endtask

    // Drive one bus cycle just after the edge; registered expectations describe the
    // state produced by all earlier cycles.
    task automatic step(input string name, input logic [15:0] a, input logic rw,
                        input logic v, input logic n, input logic r,
                        input logic e_cs, input logic e_ram, input logic e_wr,
                        input logic [1:0] e_st, input logic e_ov, input logic e_to);
        exp_t e;
        @(posedge clk);
        #1;
        cpu_addr  = a;
        cpu_rw    = rw;
        cpu_valid = v;
        nmi_n     = n;
        rst_n     = r;
        e.name = name; e.addr = a[7:0]; e.cs = e_cs; e.ram = e_ram; e.wr = e_wr;
        e.st = e_st; e.ov = e_ov; e.to = e_to;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, "ctl_addr",       {8'h00, ctl_addr},      {8'h00, e.addr});
                check(e.name, "csP",            {15'h0, csP},           {15'h0, e.cs});
                check(e.name, "ram_cs",         {15'h0, ram_cs},        {15'h0, e.ram});
                check(e.name, "write",          {15'h0, write},         {15'h0, e.wr});
                check(e.name, "state",          {14'h0, state},         {14'h0, e.st});
                check(e.name, "overlay_active", {15'h0, overlay_active}, {15'h0, e.ov});
                check(e.name, "arm_timeout",    {15'h0, arm_timeout},   {15'h0, e.to});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n = 1'b0; cpu_addr = 16'h0000; cpu_rw = 1'b1; cpu_valid = 1'b0; nmi_n = 1'b1;

        //   name          addr    rw v  n  r   cs ram wr st    ov to
        step("rst_a",      16'h0000, 1, 1, 1, 0,  0, 1, 0, 2'd0, 0, 0);
        step("rst_b",      16'h0000, 1, 0, 1, 0,  0, 0, 0, 2'd0, 0, 0);
        step("norm_vec0",  16'hFFFA, 1, 1, 1, 1,  0, 1, 0, 2'd0, 0, 0);
        step("norm_vec1",  16'hFFFA, 1, 1, 1, 1,  0, 1, 0, 2'd0, 0, 0);
        step("nmi_fall",   16'h0000, 1, 0, 0, 1,  0, 0, 0, 2'd0, 0, 0);
        step("armed",      16'h0000, 1, 0, 0, 1,  0, 0, 0, 2'd1, 0, 0);
        step("vec_hit",    16'hFFFA, 1, 1, 0, 1,  1, 0, 0, 2'd1, 0, 0);
        step("ovl_page",   16'hFF10, 1, 1, 0, 1,  1, 0, 0, 2'd2, 1, 0);
        step("ovl_ram",    16'h1234, 1, 1, 0, 1,  0, 1, 0, 2'd2, 1, 0);
        step("exit_wr",    16'hFFF8, 0, 1, 1, 1,  1, 0, 1, 2'd2, 1, 0);
        step("post_exit",  16'hFF10, 1, 1, 1, 1,  0, 1, 0, 2'd0, 0, 0);

        // Arming timeout: 64 strobes without a vector fetch.
        step("to_fall",    16'h0000, 1, 0, 0, 1,  0, 0, 0, 2'd0, 0, 0);
        for (int i = 1; i <= 64; i++)
            step("to_strobe", 16'h0200, 1, 1, 0, 1,  0, 1, 0, 2'd1, 0, 0);
        step("to_expired", 16'h0200, 1, 0, 1, 1,  0, 0, 0, 2'd0, 0, 1);

        // Re-arm clears the flag; then a hit lands exactly on the 64th strobe.
        step("rearm_fall", 16'h0000, 1, 0, 0, 1,  0, 0, 0, 2'd0, 0, 1);
        step("rearmed",    16'h0000, 1, 0, 0, 1,  0, 0, 0, 2'd1, 0, 0);
        for (int i = 1; i <= 63; i++)
            step("hit_strobe", 16'h0200, 1, 1, 0, 1,  0, 1, 0, 2'd1, 0, 0);
        step("hit64",      16'hFFFA, 1, 1, 0, 1,  1, 0, 0, 2'd1, 0, 0);
        step("hit64_ovl",  16'h0000, 1, 0, 0, 1,  0, 0, 0, 2'd2, 1, 0);

        // NMI pulse while overlaid is ignored.
        step("pulse_hi",   16'h0000, 1, 0, 1, 1,  0, 0, 0, 2'd2, 1, 0);
        step("pulse_lo",   16'h0000, 1, 0, 0, 1,  0, 0, 0, 2'd2, 1, 0);
        step("pulse_hold", 16'h0000, 1, 0, 0, 1,  0, 0, 0, 2'd2, 1, 0);
        step("pulse_page", 16'hFF10, 1, 1, 0, 1,  1, 0, 0, 2'd2, 1, 0);

        // Reset in the middle of an overlay.
        step("mid_rst",    16'h0000, 1, 1, 1, 0,  0, 1, 0, 2'd2, 1, 0);
        step("after_rst",  16'h0000, 1, 0, 1, 1,  0, 0, 0, 2'd0, 0, 0);
        step("rst_page",   16'hFF10, 1, 1, 1, 1,  0, 1, 0, 2'd0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
